// File: rtl/stream_pkg.sv
// Shared lane-packing helpers so every stream fan-in/fan-out block
// lays out flattened lanes the same way.
package stream_pkg;

    // Lowest bit of lane k in a flattened bus of WIDTH-bit lanes.
    function automatic int lane_lo(input int k, input int width);
        return k * width;
    endfunction

    // Number of lanes a SIZE-bit select can address.
    function automatic int default_outputs(input int size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register for a single demux output lane.
module demux_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             consume,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // A load wins over a same-cycle consume, so a draining lane refills without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= data_in;
        end else if (consume) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-OUTPUTS valid/ready demultiplexer; each lane has its own
// one-entry slot so a stalled lane never blocks traffic to the others.
module demux_stream
    import stream_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int SIZE    = 1,
    parameter int OUTPUTS = default_outputs(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in,
    input  logic [SIZE-1:0]            sel,
    output logic [WIDTH*OUTPUTS-1:0]   out,
    output logic [OUTPUTS-1:0]         out_valid,
    input  logic [OUTPUTS-1:0]         out_ready,
    output logic                       err
);

    logic               in_range;
    logic [OUTPUTS-1:0] load;
    logic [OUTPUTS-1:0] full;

    assign in_range  = (32'(sel) < OUTPUTS);
    assign out_valid = full;

    // Out-of-range beats are always accepted so they can be dropped and flagged.
    always_comb begin
        in_ready = 1'b1;
        load     = '0;
        for (int k = 0; k < OUTPUTS; k++) begin
            if (32'(sel) == k) begin
                in_ready = ~full[k] | out_ready[k];
                load[k]  = in_valid & (~full[k] | out_ready[k]);
            end
        end
    end

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_lane
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load   (load[k]),
            .data_in(in),
            .consume(full[k] & out_ready[k]),
            .full   (full[k]),
            .data   (out[lane_lo(k, WIDTH) +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (in_valid && !in_range) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: an 8-lane instance and a 3-lane
// instance (SIZE=2) sharing clock and reset.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst;

    logic        v8, r8, e8;
    logic [7:0]  d8;
    logic [2:0]  s8;
    logic [63:0] o8;
    logic [7:0]  ov8, or8;

    logic        v3, r3, e3;
    logic [7:0]  d3;
    logic [1:0]  s3;
    logic [23:0] o3;
    logic [2:0]  ov3, or3;

    int checks   = 0;
    int failures = 0;
    int pops8 [8];
    int waited;
    int pre;

    logic [7:0] q8 [8][$];
    logic [7:0] q3 [3][$];

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(8), .SIZE(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in(d8), .sel(s8),
        .out(o8), .out_valid(ov8), .out_ready(or8), .err(e8)
    );

    demux_stream #(.WIDTH(8), .SIZE(2), .OUTPUTS(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in(d3), .sel(s3),
        .out(o3), .out_valid(ov3), .out_ready(or3), .err(e3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed beat must match the oldest expected beat for its lane.
    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (ov8[k] && or8[k]) begin
                pops8[k]++;
                if (q8[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon8 lane %0d: got unexpected beat %0h expected none", k, o8[k*8 +: 8]);
                end else begin
                    check($sformatf("mon8_lane%0d", k), 64'(o8[k*8 +: 8]), 64'(q8[k].pop_front()));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (ov3[k] && or3[k]) begin
                if (q3[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon3 lane %0d: got unexpected beat %0h expected none", k, o3[k*8 +: 8]);
                end else begin
                    check($sformatf("mon3_lane%0d", k), 64'(o3[k*8 +: 8]), 64'(q3[k].pop_front()));
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send8(input logic [2:0] s, input logic [7:0] d, output int w);
        v8 = 1'b1;
        s8 = s;
        d8 = d;
        w  = 0;
        @(negedge clk);
        while (!r8 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (r8) begin
            q8[s].push_back(d);
        end else begin
            checks++;
            failures++;
            $display("FAIL send8_timeout: got in_ready 0 expected 1 within 10 cycles");
        end
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    initial begin
        foreach (pops8[k]) pops8[k] = 0;
        rst = 1'b1;
        v8 = 0; d8 = 0; s8 = 0; or8 = 0;
        v3 = 0; d3 = 0; s3 = 0; or3 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle
        @(negedge clk);
        check("rst_ov8", 64'(ov8), 64'h0);
        check("rst_out8", o8, 64'h0);
        check("rst_err8", 64'(e8), 64'h0);
        check("rst_err3", 64'(e3), 64'h0);
        for (int s = 0; s < 8; s++) begin
            s8 = 3'(s);
            #1 check("rst_rdy8", 64'(r8), 64'h1);
        end
        for (int s = 0; s < 4; s++) begin
            s3 = 2'(s);
            #1 check("rst_rdy3", 64'(r3), 64'h1);
        end

        // Basic steer and pass-through refill on lane 5
        @(posedge clk); #1 v8 = 1; s8 = 5; d8 = 8'hA5;
        @(negedge clk);
        check("basic_rdy", 64'(r8), 64'h1);
        q8[5].push_back(8'hA5);
        @(posedge clk); #1 d8 = 8'h3C;
        @(negedge clk);
        check("basic_ov", 64'(ov8), 64'h20);
        check("basic_lane5", 64'(o8[47:40]), 64'hA5);
        check("basic_stall", 64'(r8), 64'h0);
        @(posedge clk); #1 or8[5] = 1'b1;
        @(negedge clk);
        check("basic_pass_rdy", 64'(r8), 64'h1);
        q8[5].push_back(8'h3C);
        @(posedge clk); #1 v8 = 0; or8 = 0;
        @(negedge clk);
        check("basic_ov2", 64'(ov8), 64'h20);
        check("basic_lane5b", 64'(o8[47:40]), 64'h3C);
        @(posedge clk); #1 or8[5] = 1'b1;
        @(posedge clk); #1 or8 = 0;

        // Streaming 16 beats to lane 2
        pre = pops8[2];
        or8 = 8'h04;
        for (int i = 0; i < 16; i++) begin
            v8 = 1; s8 = 2; d8 = 8'(i);
            @(negedge clk);
            check("stream_rdy", 64'(r8), 64'h1);
            q8[2].push_back(8'(i));
            @(posedge clk); #1;
        end
        v8 = 0;
        @(posedge clk); #1;
        check("stream_count", 64'(pops8[2] - pre), 64'd16);
        @(negedge clk);
        check("stream_ov_idle", 64'(ov8), 64'h0);
        @(posedge clk); #1 or8 = 0;

        // Independence: lane 1 stalled, lanes 0 and 3 still accept
        send8(3'd1, 8'h11, waited);
        send8(3'd0, 8'h40, waited);
        check("indep_l0_wait", 64'(waited), 64'h0);
        send8(3'd3, 8'h33, waited);
        check("indep_l3_wait", 64'(waited), 64'h0);
        s8 = 1;
        #1 check("indep_l1_stall", 64'(r8), 64'h0);
        @(negedge clk);
        check("indep_ov", 64'(ov8), 64'h0B);
        check("indep_lane0", 64'(o8[7:0]), 64'h40);
        check("indep_lane3", 64'(o8[31:24]), 64'h33);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("indep_lane1_hold", 64'(o8[15:8]), 64'h11);
        @(posedge clk); #1 or8 = 8'hFF;
        @(posedge clk); #1 or8 = 0;
        @(negedge clk);
        check("indep_drained", 64'(ov8), 64'h0);

        // 3-lane instance: valid beat then out-of-range beat
        @(posedge clk); #1 v3 = 1; s3 = 2; d3 = 8'h5A;
        @(negedge clk);
        check("l3_rdy", 64'(r3), 64'h1);
        q3[2].push_back(8'h5A);
        @(posedge clk); #1 s3 = 3; d3 = 8'hEE;
        @(negedge clk);
        check("l3_ov", 64'(ov3), 64'h4);
        check("l3_lane2", 64'(o3[23:16]), 64'h5A);
        check("oor_rdy", 64'(r3), 64'h1);
        check("oor_err_pre", 64'(e3), 64'h0);
        @(posedge clk); #1 v3 = 0; s3 = 0; or3 = 3'b100;
        @(negedge clk);
        check("oor_err", 64'(e3), 64'h1);
        @(posedge clk); #1 or3 = 0;
        @(negedge clk);
        check("oor_ov", 64'(ov3), 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("oor_sticky", 64'(e3), 64'h1);

        // Reset mid-flight with a simultaneous accept to lane 2
        @(posedge clk); #1;
        send8(3'd0, 8'h01, waited);
        send8(3'd4, 8'h44, waited);
        send8(3'd7, 8'h77, waited);
        @(negedge clk);
        check("mid_ov", 64'(ov8), 64'h91);
        @(posedge clk); #1 rst = 1; v8 = 1; s8 = 2; d8 = 8'h22;
        foreach (q8[k]) q8[k].delete();
        @(posedge clk); #1 rst = 0; v8 = 0;
        @(negedge clk);
        check("mid_ov8", 64'(ov8), 64'h0);
        check("mid_out8", o8, 64'h0);
        check("mid_err3", 64'(e3), 64'h0);
        check("mid_ov3", 64'(ov3), 64'h0);
        check("mid_rdy", 64'(r8), 64'h1);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
